// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: credit-limited imem requester feeding a 2-entry IF/ID FIFO,
// with redirect flush and drop-on-stale-ack handling.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instr_addr_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q;
  logic [1:0]  cnt_q, cnt_after;
  logic [31:0] head_pc_q, head_ins_q, tail_pc_q, tail_ins_q;
  logic        push, pop;

  always_comb begin
    pop       = (cnt_q != 2'd0) && !stall_i;
    push      = (state_q == REQ) && imem_ack_i && !redirect_i;
    cnt_after = cnt_q + {1'b0, push} - {1'b0, pop};
    state_d   = state_q;
    pc_d      = pc_q;
    if (redirect_i) begin
      pc_d = redirect_addr_i & ~32'h3;
      // An un-acked request in flight must be drained before the new target is fetched.
      if (state_q != IDLE && !imem_ack_i) state_d = DROP;
      else                                state_d = REQ;
    end else begin
      case (state_q)
        IDLE: if (cnt_after < 2'd2) state_d = REQ;
        REQ: begin
          if (imem_ack_i) begin
            pc_d    = pc_q + 32'd4;
            state_d = (cnt_after < 2'd2) ? REQ : IDLE;
          end
        end
        DROP: if (imem_ack_i) state_d = REQ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      // Latched only when a fresh request starts, so DROP keeps presenting the old address.
      if (state_d == REQ) addr_q <= pc_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q      <= '0;
      head_pc_q  <= '0;
      head_ins_q <= '0;
      tail_pc_q  <= '0;
      tail_ins_q <= '0;
    end else if (redirect_i) begin
      cnt_q      <= '0;
      head_pc_q  <= '0;
      head_ins_q <= '0;
      tail_pc_q  <= '0;
      tail_ins_q <= '0;
    end else begin
      cnt_q <= cnt_after;
      // Tail is kept zero while unused so a pop shifts zeros into an emptied head.
      if (pop && push) begin
        if (cnt_q == 2'd1) begin
          head_pc_q  <= pc_q;
          head_ins_q <= imem_data_i;
        end else begin
          head_pc_q  <= tail_pc_q;
          head_ins_q <= tail_ins_q;
          tail_pc_q  <= pc_q;
          tail_ins_q <= imem_data_i;
        end
      end else if (pop) begin
        head_pc_q  <= tail_pc_q;
        head_ins_q <= tail_ins_q;
        tail_pc_q  <= '0;
        tail_ins_q <= '0;
      end else if (push) begin
        if (cnt_q == 2'd0) begin
          head_pc_q  <= pc_q;
          head_ins_q <= imem_data_i;
        end else begin
          tail_pc_q  <= pc_q;
          tail_ins_q <= imem_data_i;
        end
      end
    end
  end

  assign imem_req_o   = (state_q != IDLE);
  assign imem_addr_o  = (state_q != IDLE) ? addr_q : '0;
  assign valid_o      = (cnt_q != 2'd0);
  assign instr_o      = head_ins_q;
  assign instr_addr_o = head_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: the expected instruction stream is the
// sequential program order from the last reset/redirect target, data = f(address).
module tb_instr_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_i, stall_i, redirect_i, imem_ack_i;
  logic [31:0] redirect_addr_i, imem_data_i;
  logic        imem_req_o, valid_o;
  logic [31:0] imem_addr_o, instr_addr_o, instr_o;

  instr_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_addr_i(redirect_addr_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i), .instr_addr_o(instr_addr_o),
    .instr_o(instr_o), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int delivered = 0;
  int lat = 0;
  bit idle_noise = 1'b0;
  bit chk_lat = 1'b0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected program order from a new fetch target.
  task automatic restart(input logic [31:0] t);
    logic [31:0] a;
    a = t & ~32'h3;
    exp_q.delete();
    for (int unsigned i = 0; i < 1024; i++) exp_q.push_back(a + 32'd4 * i);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_valid(input string name);
    int unsigned k;
    k = 0;
    while (!valid_o && k < 60) begin cyc(1); k++; end
    if (!valid_o) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Memory model: acks after `lat` wait cycles, returns f(addr).
  int wcnt = 0;
  always @(posedge clk) begin
    #1;
    if (!rst_i) begin
      wcnt = 0;
      imem_ack_i = idle_noise;
      imem_data_i = $urandom;
    end else if (imem_req_o) begin
      if (wcnt >= lat) begin
        imem_ack_i = 1'b1;
        imem_data_i = f(imem_addr_o);
        wcnt = 0;
      end else begin
        imem_ack_i = 1'b0;
        imem_data_i = $urandom;
        wcnt++;
      end
    end else begin
      wcnt = 0;
      imem_ack_i = idle_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_data_i = $urandom;
    end
  end

  // Monitor: pops the scoreboard on every accepted output, checks request stability.
  logic [31:0] p_addr;
  logic        p_req = 1'b0, p_ack = 1'b0, p_stall = 1'b0, p_redir = 1'b0, p_ok = 1'b0;
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_i) begin
      if (p_ok && p_req && !p_ack && imem_req_o) chk("addr_hold", imem_addr_o, p_addr);
      if (chk_lat && p_ok) begin
        if (p_req && p_ack && !p_stall && !p_redir) begin
          chk("lat_valid", {31'd0, valid_o}, 32'd1);
          chk("lat_addr", instr_addr_o, p_addr);
        end else begin
          chk("lat_gap", {31'd0, valid_o}, 32'd0);
        end
      end
      if (valid_o && !stall_i && !redirect_i) begin
        if (exp_q.size() == 0) begin
          chk("stream_unexpected", instr_addr_o, 32'hDEAD_DEAD);
        end else begin
          e = exp_q.pop_front();
          chk("stream_addr", instr_addr_o, e);
          chk("stream_data", instr_o, f(e));
          delivered++;
        end
      end
    end
    p_ok = rst_i; p_req = imem_req_o; p_ack = imem_ack_i; p_addr = imem_addr_o;
    p_stall = stall_i; p_redir = redirect_i;
  end

  initial begin
    int unsigned k;
    int d0;
    logic [31:0] held, ra;
    rst_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_addr_i = '0;
    imem_ack_i = 1'b0; imem_data_i = '0;
    restart(RPC);
    #3;
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_addr", imem_addr_o, 32'd0);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_iaddr", instr_addr_o, 32'd0);
    cyc(2);
    rst_i = 1'b1;
    cyc(1);
    chk("first_req", {31'd0, imem_req_o}, 32'd1);
    chk("first_addr", imem_addr_o, RPC);

    // Zero-wait: one instruction per cycle.
    for (int unsigned i = 0; i < 4; i++) begin
      cyc(1);
      chk("zw_valid", {31'd0, valid_o}, 32'd1);
      chk("zw_addr", instr_addr_o, RPC + 32'd4 * i);
    end

    // Stall fills the FIFO and stops requesting.
    cyc(3);
    stall_i = 1'b1;
    held = instr_o;
    cyc(5);
    chk("stall_req", {31'd0, imem_req_o}, 32'd0);
    chk("stall_hold", instr_o, held);
    chk("stall_valid", {31'd0, valid_o}, 32'd1);
    d0 = delivered;
    stall_i = 1'b0;
    cyc(10);
    chk("stall_resume", {31'd0, 1'(delivered - d0 >= 8)}, 32'd1);

    // Three-cycle ack latency.
    lat = 2;
    cyc(8);
    chk_lat = 1'b1;
    cyc(30);
    chk_lat = 1'b0;

    // Redirect with one FIFO entry and an un-acked request.
    stall_i = 1'b1;
    k = 0;
    while (!(valid_o && imem_req_o && !imem_ack_i) && k < 40) begin cyc(1); k++; end
    chk("r030_setup", {31'd0, 1'(valid_o && imem_req_o && !imem_ack_i)}, 32'd1);
    redirect_i = 1'b1; redirect_addr_i = 32'h0000_0103;
    restart(32'h0000_0103);
    cyc(1);
    redirect_i = 1'b0; stall_i = 1'b0;
    chk("r030_flush", {31'd0, valid_o}, 32'd0);
    wait_valid("r030");
    chk("r030_target", instr_addr_o, 32'h0000_0100);

    // Redirect together with an ack while stalled.
    lat = 0;
    stall_i = 1'b1;
    k = 0;
    while (!(imem_req_o && imem_ack_i) && k < 40) begin cyc(1); k++; end
    chk("r031_setup", {31'd0, 1'(imem_req_o && imem_ack_i)}, 32'd1);
    redirect_i = 1'b1; redirect_addr_i = 32'h0000_2000;
    restart(32'h0000_2000);
    cyc(1);
    redirect_i = 1'b0;
    chk("r031_flush", {31'd0, valid_o}, 32'd0);
    wait_valid("r031");
    chk("r031_addr", instr_addr_o, 32'h0000_2000);
    chk("r031_data", instr_o, f(32'h0000_2000));

    // Wrap at the top of the address space.
    redirect_i = 1'b1; redirect_addr_i = 32'hFFFF_FFFC;
    restart(32'hFFFF_FFFC);
    cyc(1);
    redirect_i = 1'b0;
    wait_valid("wrap0");
    chk("wrap_top", instr_addr_o, 32'hFFFF_FFFC);
    stall_i = 1'b0;
    cyc(1);
    wait_valid("wrap1");
    chk("wrap_zero", instr_addr_o, 32'h0000_0000);

    // Reset in the middle of a request.
    lat = 3; idle_noise = 1'b1;
    k = 0;
    while (!(imem_req_o && !imem_ack_i) && k < 40) begin cyc(1); k++; end
    rst_i = 1'b0;
    #1;
    chk("mrst_req", {31'd0, imem_req_o}, 32'd0);
    chk("mrst_addr", imem_addr_o, 32'd0);
    chk("mrst_valid", {31'd0, valid_o}, 32'd0);
    chk("mrst_instr", instr_o, 32'd0);
    chk("mrst_iaddr", instr_addr_o, 32'd0);
    restart(RPC);
    cyc(2);
    rst_i = 1'b1;
    cyc(1);
    chk("mrst_restart_req", {31'd0, imem_req_o}, 32'd1);
    chk("mrst_restart_addr", imem_addr_o, RPC);

    // Randomized traffic.
    d0 = delivered;
    for (int unsigned i = 0; i < 1500; i++) begin
      if (i % 50 == 0) lat = int'($urandom_range(0, 3));
      stall_i = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 24) == 0) begin
        ra = $urandom;
        redirect_i = 1'b1; redirect_addr_i = ra;
        restart(ra);
      end else begin
        redirect_i = 1'b0;
      end
      cyc(1);
    end
    redirect_i = 1'b0; stall_i = 1'b0;
    cyc(30);
    chk("rand_progress", {31'd0, 1'(delivered - d0 > 100)}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
